// File: rtl/traffic_pkg.sv
// Shared constants for the traffic sensor front end and the traffic_light controller.
package traffic_pkg;

   localparam int HIST_W             = 8;
   localparam int DEF_SAMPLE_PERIOD  = 50;
   localparam int DEF_DEBOUNCE       = 4;
   localparam int DEF_CNT_W          = 4;

   // Light encodings must stay in step with traffic_light.
   typedef enum logic [2:0] {
      RED    = 3'b100,
      YELLOW = 3'b010,
      GREEN  = 3'b001
   } light_t;

endpackage

// File: rtl/sensor_channel.sv
// One detector channel: 2-flop sync, debounce, rise detect, window hit flag and saturating count.
// TRAFFIC_SENSOR_OCCUPANCY_EN: hit flag tracks "debounced level high" instead of "arrival seen".
module sensor_channel
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE = DEF_DEBOUNCE,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sens,
   input  logic             win_end,
   output logic             hit_eff,
   output logic [CNT_W-1:0] cnt_eff
);

   localparam int               STAB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic              deb_q, deb_d;
   logic              deb_dly_q, deb_dly_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic              hit_q, hit_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rise;

   always_comb begin
      sync1_d   = sens;
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      stab_d    = '0;
      deb_dly_d = deb_q;
      if (sync2_q != deb_q) begin
         if (stab_q == STAB_MAX) begin
            deb_d = ~deb_q;
         end else begin
            stab_d = stab_q + 1'b1;
         end
      end

      rise = deb_q & ~deb_dly_q;
`ifdef TRAFFIC_SENSOR_OCCUPANCY_EN
      hit_eff = hit_q | deb_q;
`else
      hit_eff = hit_q | rise;
`endif
      // The effective values fold in this cycle's event so a terminal-cycle arrival closes with its window.
      cnt_eff = (rise && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
      hit_d   = win_end ? 1'b0 : hit_eff;
      cnt_d   = win_end ? '0   : cnt_eff;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 1'b0;
         deb_dly_q <= 1'b0;
         stab_q    <= '0;
         hit_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         stab_q    <= stab_d;
         hit_q     <= hit_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: rtl/traffic_sensor.sv
// Traffic sensor top: window timer plus per-road 8-bit history and last-window arrival count.
// TRAFFIC_SENSOR_OCCUPANCY_EN selects occupancy meaning for the history bits (see sensor_channel).
module traffic_sensor
   import traffic_pkg::*;
#(
   parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
   parameter int DEBOUNCE      = DEF_DEBOUNCE,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sensA,
   input  logic              sensB,
   output logic [HIST_W-1:0] lastA,
   output logic [HIST_W-1:0] lastB,
   output logic [CNT_W-1:0]  carsA,
   output logic [CNT_W-1:0]  carsB,
   output logic              sample_tick
);

   localparam int                WCNT_W = $clog2(SAMPLE_PERIOD);
   localparam logic [WCNT_W-1:0] WLAST  = WCNT_W'(SAMPLE_PERIOD - 1);

   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              tick_q, tick_d;
   logic              win_end;
   logic [1:0]        sens_w;

   assign sens_w = {sensB, sensA};

   always_comb begin
      win_end = (wcnt_q == WLAST);
      wcnt_d  = win_end ? '0 : wcnt_q + 1'b1;
      tick_d  = win_end;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wcnt_q <= '0;
         tick_q <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         tick_q <= tick_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         logic              hit_eff;
         logic [CNT_W-1:0]  cnt_eff;
         logic [HIST_W-1:0] last_q, last_d;
         logic [CNT_W-1:0]  cars_q, cars_d;

         sensor_channel #(
            .DEBOUNCE (DEBOUNCE),
            .CNT_W    (CNT_W)
         ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .sens    (sens_w[gi]),
            .win_end (win_end),
            .hit_eff (hit_eff),
            .cnt_eff (cnt_eff)
         );

         always_comb begin
            last_d = last_q;
            cars_d = cars_q;
            if (win_end) begin
               last_d = {last_q[HIST_W-2:0], hit_eff};
               cars_d = cnt_eff;
            end
         end

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               last_q <= '0;
               cars_q <= '0;
            end else begin
               last_q <= last_d;
               cars_q <= cars_d;
            end
         end
      end
   endgenerate

   assign lastA       = g_ch[0].last_q;
   assign lastB       = g_ch[1].last_q;
   assign carsA       = g_ch[0].cars_q;
   assign carsB       = g_ch[1].cars_q;
   assign sample_tick = tick_q;

endmodule

// File: tb/tb_traffic_sensor.sv
// Directed bench for traffic_sensor: reset, bounce filter, arrivals, saturation, window boundary, aging.
module tb_traffic_sensor;

   logic       clock = 1'b0;
   logic       reset;
   logic       sensA, sensB, sensA_s, sensB_s;
   logic [7:0] lastA, lastB, lastA_s, lastB_s;
   logic [3:0] carsA, carsB, carsA_s, carsB_s;
   logic       tick, tick_s;

   int checks = 0;
   int errors = 0;

`ifdef TRAFFIC_SENSOR_OCCUPANCY_EN
   localparam logic [7:0] HELD_NEXT = 8'h03;
`else
   localparam logic [7:0] HELD_NEXT = 8'h02;
`endif

   always #5 clock = ~clock;

   traffic_sensor dut (
      .clock(clock), .reset(reset), .sensA(sensA), .sensB(sensB),
      .lastA(lastA), .lastB(lastB), .carsA(carsA), .carsB(carsB),
      .sample_tick(tick)
   );

   traffic_sensor #(.SAMPLE_PERIOD(300)) dut_sat (
      .clock(clock), .reset(reset), .sensA(sensA_s), .sensB(sensB_s),
      .lastA(lastA_s), .lastB(lastB_s), .carsA(carsA_s), .carsB(carsB_s),
      .sample_tick(tick_s)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_tick(input bit sel, input int max_cyc, output int n);
      logic seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < max_cyc) begin
         step();
         n++;
         seen = sel ? tick_s : tick;
      end
      check_eq(sel ? "tick_s_seen" : "tick_seen", {31'b0, seen}, 32'd1);
   endtask

   task automatic do_reset();
      sensA = 0; sensB = 0; sensA_s = 0; sensB_s = 0;
      reset = 0;
      step();
      reset = 1;
   endtask

   initial begin
      int n;
      reset = 0; sensA = 0; sensB = 1; sensA_s = 0; sensB_s = 0;

      // Reset held with toggling sensors
      for (int i = 0; i < 5; i++) begin
         sensA = ~sensA; sensB = ~sensB;
         step();
      end
      check_eq("rst_lastA", lastA, 0);
      check_eq("rst_lastB", lastB, 0);
      check_eq("rst_carsA", carsA, 0);
      check_eq("rst_carsB", carsB, 0);
      check_eq("rst_tick",  tick,  0);
      sensA = 0; sensB = 0;
      reset = 1;
      wait_tick(0, 200, n);
      check_eq("first_tick_cycles", n, 50);
      check_eq("first_lastA", lastA, 0);
      check_eq("first_lastB", lastB, 0);
      step();
      check_eq("tick_one_cycle", tick, 0);

      // Bounce filter: 1..3 cycle pulses on both roads for 8 windows
      do_reset();
      wait_tick(0, 100, n);
      for (int w = 0; w < 8; w++) begin
         for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 8; c++) begin
               sensA = (c < ((w + p) % 3) + 1);
               sensB = (c < ((w + p + 1) % 3) + 1);
               step();
            end
         end
         wait_tick(0, 100, n);
      end
      check_eq("bounce_lastA", lastA, 8'h00);
      check_eq("bounce_carsA", carsA, 0);
      check_eq("bounce_lastB", lastB, 8'h00);

      // Single held arrival from window cycle 10
      do_reset();
      wait_tick(0, 100, n);
      steps(10);
      sensA = 1;
      wait_tick(0, 100, n);
      check_eq("single_lastA", lastA, 8'h01);
      check_eq("single_carsA", carsA, 1);
      check_eq("single_lastB", lastB, 8'h00);
      wait_tick(0, 100, n);
      check_eq("held_lastA", lastA, HELD_NEXT);
      check_eq("held_carsA", carsA, 0);

      // Saturation on the 300-cycle instance: 20 clean pulses on B
      do_reset();
      wait_tick(1, 400, n);
      check_eq("sat_period", n, 300);
      for (int p = 0; p < 20; p++) begin
         sensB_s = 1; steps(6);
         sensB_s = 0; steps(6);
      end
      wait_tick(1, 400, n);
      check_eq("sat_carsB", carsB_s, 15);
      check_eq("sat_lastB", lastB_s, 8'h01);
      check_eq("sat_carsA", carsA_s, 0);
      check_eq("sat_lastA", lastA_s, 8'h00);
      wait_tick(1, 400, n);
      check_eq("sat_next_carsB", carsB_s, 0);
      check_eq("sat_next_lastB", lastB_s, 8'h02);

      // Boundary: raw rise at cycle 43 gives the arrival in the terminal cycle
      do_reset();
      wait_tick(0, 100, n);
      steps(43);
      sensA = 1;
      wait_tick(0, 100, n);
      check_eq("bnd49_cycles", n, 7);
      check_eq("bnd49_lastA", lastA, 8'h01);
      check_eq("bnd49_carsA", carsA, 1);
      wait_tick(0, 100, n);
      check_eq("bnd49_next_carsA", carsA, 0);
      check_eq("bnd49_next_lastA", lastA, HELD_NEXT);

      // One cycle later the arrival lands in cycle 0 of the next window
      do_reset();
      wait_tick(0, 100, n);
      steps(44);
      sensA = 1;
      wait_tick(0, 100, n);
      check_eq("bnd50_lastA", lastA, 8'h00);
      check_eq("bnd50_carsA", carsA, 0);
      wait_tick(0, 100, n);
      check_eq("bnd50_next_lastA", lastA, 8'h01);
      check_eq("bnd50_next_carsA", carsA, 1);

      // Aging: arrival pulse in windows 0, 4, 8
      do_reset();
      wait_tick(0, 100, n);
      for (int w = 0; w < 12; w++) begin
         if (w % 4 == 0) begin
            steps(5);
            sensA = 1; steps(8);
            sensA = 0;
         end
         wait_tick(0, 100, n);
         if (w == 8) begin
            check_eq("age_w8_lastA", lastA, 8'h11);
            check_eq("age_w8_carsA", carsA, 1);
         end
         if (w == 11) begin
            check_eq("age_w11_lastA", lastA, 8'h88);
            check_eq("age_w11_carsA", carsA, 0);
         end
      end
      steps(20);
      reset = 0;
      #1;
      check_eq("midrst_lastA", lastA, 0);
      check_eq("midrst_carsA", carsA, 0);
      check_eq("midrst_tick",  tick,  0);
      step();
      reset = 1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
